marquee_seq_ctrl: RTL and testbench
===================================

Name: marquee_seq_ctrl

Overview:
- Sequencer for the 8-digit scrolling marquee.
- Holds a small message table and plays it in order. Each message is scrolled for a fixed number of full rotations, then held static, then the next message loads.
- Outputs the rotated sequence word and the current position, ready for the segment scan/decoder path.
- Runs off the system clock; stepping uses an internal enable tick, not a derived clock.

Parameters:
- N, 32, message width in bits.
- WIDTH, 4, bits per digit; DIGITS = N/WIDTH.
- NMSG, 4, message table depth (≥2).
- STEP_DIV, 50_000_000, sys_clk cycles per scroll step (≥2).
- HOLD_STEPS, 8, steps the message is held unrotated after scrolling (≥1).
- LOOPS, 2, full rotations per message (≥1).

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous, active-high reset.
- start  in  1  begin playback from message 0 (level sampled each cycle).
- stop  in  1  abort playback.
- dir  in  1  scroll direction, 1 = right (pos increments), 0 = left (pos decrements).
- msg_we  in  1  message table write strobe.
- msg_waddr  in  $clog2(NMSG)  write address.
- msg_wdata  in  N  write data.
- seq_out  out  N  rotated current message.
- pos  out  $clog2(DIGITS)  current rotation position.
- msg_idx  out  $clog2(NMSG)  index of the message being played.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a pass completes.

Behaviour:
Reset:
- Synchronous, active-high.
- Reset state: FSM=IDLE, pos=0, msg_idx=0, seq_out=0, done=0, busy=0, tick counter=0, current-message register=0.
- Message table contents are also cleared to 0.

Table writes:
- Accepted in any state.
- Take effect on the next LOAD only; the message currently playing is latched and unaffected.

Step tick:
- Counter runs 0..STEP_DIV-1 only in SCROLL and HOLD; tick asserts when counter==STEP_DIV-1.
- Counter clears on LOAD, so the first step comes exactly STEP_DIV cycles after entering SCROLL.

FSM states and transitions:
- IDLE: on start && !stop → LOAD with msg_idx=0. seq_out keeps its last value.
- LOAD (1 cycle): latch table[msg_idx] into the current register; pos=0; step count=0 → SCROLL.
- SCROLL: on each tick, pos = pos+1 mod DIGITS (dir=1) or pos-1 mod DIGITS (dir=0); step count increments. dir is sampled per tick, so a mid-scroll change takes effect on the next step. After LOOPS*DIGITS ticks → HOLD with pos forced to 0.
- HOLD: after HOLD_STEPS ticks, if msg_idx<NMSG-1 then msg_idx+1 → LOAD; otherwise → DONE.
- DONE (1 cycle): done=1 → IDLE; msg_idx keeps NMSG-1.

seq_out arithmetic:
- Registered, 1-cycle latency after the pos/current-register update.
- Value: (cur >> WIDTH*pos) | (cur << (N - WIDTH*pos)), truncated to N bits.
- pos=0 must yield cur exactly; no shift by N is performed.

Priorities:
- stop in any non-IDLE state → IDLE next cycle; no done pulse; pos and msg_idx hold their values.
- stop wins over start in the same cycle.
- start while busy is ignored.
- sys_rst overrides everything, including mid-LOAD and mid-HOLD.

Optional Feature:
- Macro: MARQUEE_SEQ_WRAP_EN.
- Defined: after the last message's HOLD, wrap to msg_idx=0 → LOAD. DONE is never entered and done stays 0. Playback runs until stop or reset.
- Undefined: single pass ending in DONE as above.

Decomposition:
- Package marquee_pkg:
  - state enum (IDLE, LOAD, SCROLL, HOLD, DONE);
  - DIGITS localparam function;
  - position and index width helper functions.
- One sub-module: marquee_step_tick, the clear-able enable-tick divider (STEP_DIV parameter; inputs run and clr; output tick).
- Rotation logic stays inline.

Test Plan:
Common parameters: N=32, WIDTH=4, NMSG=2, STEP_DIV=3, HOLD_STEPS=2, LOOPS=1.
1. Write table[0]=0x12345678 and table[1]=0xABCDEF01, start with dir=1 → seq_out walks 0x12345678, 0x81234567, 0x78123456, … one step every 3 cycles. After 8 steps, HOLD shows 0x12345678 for 6 cycles, then 0xABCDEF01 loads and msg_idx=1.
2. Same run with dir=0 → first step gives pos=7, seq_out=0x23456781.
3. Full pass completes → exactly one done pulse, busy falls the same cycle as DONE exits, and state is IDLE afterwards.
4. Assert stop mid-SCROLL at pos=3 → IDLE next cycle, pos holds 3, no done pulse. Start and stop asserted together in IDLE → stays IDLE.
5. Write table[0]=0xFFFF0000 while message 0 is scrolling → the current scroll is unchanged; the new value appears on the next pass.
6. With MARQUEE_SEQ_WRAP_EN defined → after message 1's HOLD, msg_idx returns to 0 and done stays 0 for 3 passes. Pulse sys_rst mid-HOLD → all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/marquee_pkg.sv
// Shared state encoding and sizing helpers for the 8-digit marquee sequencer.
package marquee_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCROLL,
        HOLD,
        DONE
    } state_t;

    function automatic int digits_of(input int n, input int width);
        return n / width;
    endfunction

    function automatic int pos_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

    function automatic int idx_width(input int nmsg);
        return (nmsg > 1) ? $clog2(nmsg) : 1;
    endfunction

    // Step counter must hold the larger of the scroll and hold step counts.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/marquee_step_tick.sv
// Clear-able enable-tick divider: one-cycle tick every STEP_DIV cycles while run is high.
module marquee_step_tick #(
    parameter int STEP_DIV = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clr) begin
            count <= '0;
        end else if (run) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign tick = run && (count == LAST);

endmodule

// File: rtl/marquee_seq_ctrl.sv
// Marquee sequencer: plays a message table, scrolling then holding each message.
// Define MARQUEE_SEQ_WRAP_EN to loop playback forever instead of ending in DONE.
module marquee_seq_ctrl
    import marquee_pkg::*;
#(
    parameter  int N          = 32,
    parameter  int WIDTH      = 4,
    parameter  int NMSG       = 4,
    parameter  int STEP_DIV   = 50_000_000,
    parameter  int HOLD_STEPS = 8,
    parameter  int LOOPS      = 2,
    localparam int DIGITS     = digits_of(N, WIDTH),
    localparam int PW         = pos_width(DIGITS),
    localparam int IW         = idx_width(NMSG)
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          start,
    input  logic          stop,
    input  logic          dir,
    input  logic          msg_we,
    input  logic [IW-1:0] msg_waddr,
    input  logic [N-1:0]  msg_wdata,
    output logic [N-1:0]  seq_out,
    output logic [PW-1:0] pos,
    output logic [IW-1:0] msg_idx,
    output logic          busy,
    output logic          done
);

    localparam int SCROLL_STEPS = LOOPS * DIGITS;
    localparam int CW = cnt_width(SCROLL_STEPS, HOLD_STEPS);
    localparam int SW = $clog2(2 * N);

    localparam logic [PW-1:0] POS_LAST    = PW'(DIGITS - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(NMSG - 1);
    localparam logic [CW-1:0] SCROLL_LAST = CW'(SCROLL_STEPS - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_STEPS - 1);

    state_t         state;
    logic [N-1:0]   msg_table [NMSG];
    logic [N-1:0]   cur;
    logic [CW-1:0]  step_cnt;
    logic           tick;
    logic           tick_run;
    logic           tick_clr;
    logic [2*N-1:0] doubled;
    logic [SW-1:0]  shamt;
    logic [N-1:0]   rotated;
    logic [PW-1:0]  pos_next;

    assign tick_run = (state == SCROLL) || (state == HOLD);
    assign tick_clr = (state == LOAD);

    marquee_step_tick #(
        .STEP_DIV (STEP_DIV)
    ) u_step_tick (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .run     (tick_run),
        .clr     (tick_clr),
        .tick    (tick)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NMSG; i++) begin
                msg_table[i] <= '0;
            end
        end else if (msg_we) begin
            msg_table[msg_waddr] <= msg_wdata;
        end
    end

    // Selecting an N-bit window of {cur,cur} rotates without ever shifting by N.
    always_comb begin
        doubled = {cur, cur};
        shamt   = SW'(pos) * SW'(WIDTH);
        rotated = doubled[shamt +: N];
    end

    always_comb begin
        pos_next = pos;
        if (dir) begin
            pos_next = (pos == POS_LAST) ? '0 : pos + 1'b1;
        end else begin
            pos_next = (pos == '0) ? POS_LAST : pos - 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            pos      <= '0;
            msg_idx  <= '0;
            cur      <= '0;
            step_cnt <= '0;
            seq_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            seq_out <= rotated;
            done    <= 1'b0;
            if (stop && (state != IDLE)) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            state   <= LOAD;
                            msg_idx <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    LOAD: begin
                        cur      <= msg_table[msg_idx];
                        pos      <= '0;
                        step_cnt <= '0;
                        state    <= SCROLL;
                    end
                    SCROLL: begin
                        if (tick) begin
                            if (step_cnt == SCROLL_LAST) begin
                                pos      <= '0;
                                step_cnt <= '0;
                                state    <= HOLD;
                            end else begin
                                pos      <= pos_next;
                                step_cnt <= step_cnt + 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (tick) begin
                            if (step_cnt == HOLD_LAST) begin
                                step_cnt <= '0;
                                if (msg_idx != IDX_LAST) begin
                                    msg_idx <= msg_idx + 1'b1;
                                    state   <= LOAD;
                                end else begin
`ifdef MARQUEE_SEQ_WRAP_EN
                                    msg_idx <= '0;
                                    state   <= LOAD;
`else
                                    state   <= DONE;
                                    done    <= 1'b1;
`endif
                                end
                            end else begin
                                step_cnt <= step_cnt + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_marquee_seq_ctrl.sv
// Directed bench for marquee_seq_ctrl with small parameters (NMSG=2, STEP_DIV=3, HOLD_STEPS=2, LOOPS=1).
module tb_marquee_seq_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic        stop;
    logic        dir;
    logic        msg_we;
    logic [0:0]  msg_waddr;
    logic [31:0] msg_wdata;
    logic [31:0] seq_out;
    logic [2:0]  pos;
    logic [0:0]  msg_idx;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    int done_pulses = 0;

    marquee_seq_ctrl #(
        .N          (32),
        .WIDTH      (4),
        .NMSG       (2),
        .STEP_DIV   (3),
        .HOLD_STEPS (2),
        .LOOPS      (1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .stop      (stop),
        .dir       (dir),
        .msg_we    (msg_we),
        .msg_waddr (msg_waddr),
        .msg_wdata (msg_wdata),
        .seq_out   (seq_out),
        .pos       (pos),
        .msg_idx   (msg_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (done === 1'b1) done_pulses++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic d);
        start = s;
        stop  = p;
        dir   = d;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic writeMsg(input logic [0:0] a, input logic [31:0] d);
        msg_we    = 1'b1;
        msg_waddr = a;
        msg_wdata = d;
        cycles(1);
        msg_we    = 1'b0;
    endtask

    initial begin
        sys_rst   = 1'b1;
        msg_we    = 1'b0;
        msg_waddr = '0;
        msg_wdata = '0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        cycles(2);
        checkOutput("rst_seq", seq_out, 32'h0);
        checkOutput("rst_pos", 32'(pos), 32'd0);
        checkOutput("rst_idx", 32'(msg_idx), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        sys_rst = 1'b0;

        writeMsg(1'b0, 32'h12345678);
        writeMsg(1'b1, 32'hABCDEF01);

        // Full pass, scrolling right; cycle numbers count edges after start is sampled.
        applyStimulus(1'b1, 1'b0, 1'b1);
        cycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("load_busy", 32'(busy), 32'd1);
        checkOutput("load_idx", 32'(msg_idx), 32'd0);
        cycles(2);
        checkOutput("first_word", seq_out, 32'h12345678);
        cycles(1);
        checkOutput("no_early_step", 32'(pos), 32'd0);
        cycles(1);
        checkOutput("step1_pos", 32'(pos), 32'd1);
        cycles(1);
        checkOutput("step1_word", seq_out, 32'h81234567);
        cycles(3);
        checkOutput("step2_word", seq_out, 32'h78123456);
        cycles(15);
        checkOutput("step7_word", seq_out, 32'h23456781);
        cycles(2);
        checkOutput("hold_pos", 32'(pos), 32'd0);
        checkOutput("hold_idx", 32'(msg_idx), 32'd0);
        cycles(1);
        checkOutput("hold_word", seq_out, 32'h12345678);
        cycles(4);
        checkOutput("hold_end_idx", 32'(msg_idx), 32'd0);
        cycles(1);
        checkOutput("next_idx", 32'(msg_idx), 32'd1);
        checkOutput("hold_word_last", seq_out, 32'h12345678);
        cycles(2);
        checkOutput("msg1_word", seq_out, 32'hABCDEF01);
        cycles(28);
        checkOutput("pre_done", 32'(done), 32'd0);
        checkOutput("pre_done_busy", 32'(busy), 32'd1);
        cycles(1);
`ifdef MARQUEE_SEQ_WRAP_EN
        checkOutput("wrap_idx", 32'(msg_idx), 32'd0);
        checkOutput("wrap_done", 32'(done), 32'd0);
        checkOutput("wrap_busy", 32'(busy), 32'd1);
        cycles(1);
        checkOutput("wrap_busy2", 32'(busy), 32'd1);
        checkOutput("wrap_done2", 32'(done), 32'd0);
`else
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("done_busy", 32'(busy), 32'd1);
        checkOutput("done_idx", 32'(msg_idx), 32'd1);
        cycles(1);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_idx", 32'(msg_idx), 32'd1);
`endif
        applyStimulus(1'b0, 1'b1, 1'b1);
        cycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("stopped_busy", 32'(busy), 32'd0);

        // Left scroll, then flip direction mid-scroll and stop at pos 3.
        applyStimulus(1'b1, 1'b0, 1'b0);
        cycles(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        cycles(4);
        checkOutput("left_pos", 32'(pos), 32'd7);
        cycles(1);
        checkOutput("left_word", seq_out, 32'h23456781);
        applyStimulus(1'b0, 1'b0, 1'b1);
        cycles(2);
        checkOutput("dir_flip_pos", 32'(pos), 32'd0);
        cycles(9);
        checkOutput("pos3", 32'(pos), 32'd3);
        applyStimulus(1'b0, 1'b1, 1'b1);
        cycles(1);
        checkOutput("stop_busy", 32'(busy), 32'd0);
        checkOutput("stop_pos", 32'(pos), 32'd3);
        checkOutput("stop_idx", 32'(msg_idx), 32'd0);
        checkOutput("stop_done", 32'(done), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        cycles(1);
        checkOutput("start_stop_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        cycles(1);
        checkOutput("idle_hold_busy", 32'(busy), 32'd0);
        checkOutput("idle_hold_word", seq_out, 32'h67812345);

        // Table write while message 0 scrolls only shows up on the next pass.
        applyStimulus(1'b1, 1'b0, 1'b1);
        cycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        cycles(2);
        writeMsg(1'b0, 32'hFFFF0000);
        cycles(2);
        checkOutput("latched_word", seq_out, 32'h81234567);
        applyStimulus(1'b0, 1'b1, 1'b1);
        cycles(1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        cycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        cycles(2);
        checkOutput("new_pass_word", seq_out, 32'hFFFF0000);

        // Reset in the middle of HOLD.
        cycles(25);
        checkOutput("mid_hold_busy", 32'(busy), 32'd1);
        checkOutput("mid_hold_word", seq_out, 32'hFFFF0000);
        sys_rst = 1'b1;
        cycles(1);
        sys_rst = 1'b0;
        checkOutput("hrst_seq", seq_out, 32'h0);
        checkOutput("hrst_pos", 32'(pos), 32'd0);
        checkOutput("hrst_idx", 32'(msg_idx), 32'd0);
        checkOutput("hrst_busy", 32'(busy), 32'd0);
        checkOutput("hrst_done", 32'(done), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        cycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        cycles(2);
        checkOutput("cleared_table", seq_out, 32'h0);
        checkOutput("cleared_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        cycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("final_busy", 32'(busy), 32'd0);

`ifdef MARQUEE_SEQ_WRAP_EN
        checkOutput("done_count", 32'(done_pulses), 32'd0);
`else
        checkOutput("done_count", 32'(done_pulses), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
